alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameters: none; the datapath SHALL be fixed at 32 bits and the shift amount at 5 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 alu_control_line  input  4  operation code from the ALU control stage.
REQ-007 shift  input  5  shift amount from the ALU control stage.
REQ-008 a  input  32  operand A (rs).
REQ-009 b  input  32  operand B (rt or extended immediate); this is also the shift source.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  32  registered result.
REQ-013 zero  output  1  registered flag; high when result == 0.
REQ-014 overflow  output  1  registered signed-overflow flag.

Function
REQ-015 A request SHALL be accepted on the cycle where in_valid && in_ready; the operands, code and shift SHALL be captured on that edge.
REQ-016 Op codes SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB (a-b)
- 0111 SLT (signed, result 1/0)
- 1000 XOR
- 1100 NOR
- 0011 SLL b
- 0100 SRL b
- 0101 SRA b
REQ-017 Any other code SHALL produce result=0, overflow=0, zero=1, with 1-cycle latency.
REQ-018 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-019 IDLE: in_ready=1 and out_valid=0.
- Accepting a non-shift op, or a shift with shift=0, SHALL go to DONE.
- Accepting a shift with shift>0 SHALL go to SHIFT.
REQ-020 Non-shift ops SHALL complete in one cycle: accepted at edge N, out_valid=1 after edge N.
REQ-021 SHIFT: the working register SHALL shift by exactly 1 bit per cycle, and a 5-bit down-counter loaded with shift SHALL decrement each cycle.
- When the counter reaches 0 the FSM SHALL go to DONE.
- Total latency SHALL be shift+1 edges from acceptance to out_valid.
- in_ready=0 in this state.
REQ-022 Fill bits: SLL and SRL SHALL fill with 0; SRA SHALL replicate b[31] every step.
REQ-023 DONE: out_valid=1; result, zero and overflow SHALL be held stable while out_ready=0.
REQ-024 DONE handshake: in_ready=out_ready.
- out_ready=1 and in_valid=1: the new request SHALL be accepted on the same edge, with transitions as from IDLE (back-to-back throughput of 1 per cycle for non-shift ops).
- out_ready=1 and in_valid=0: the FSM SHALL return to IDLE.
REQ-025 ADD/SUB SHALL use 32-bit wrap-around arithmetic.
- overflow=1 when the operand signs cause signed overflow (ADD: a, b same sign and result sign differs; SUB: a, b differ in sign and result sign differs from a).
- overflow SHALL be 0 for all other ops.
REQ-026 SLT SHALL compare signed values correctly even when a-b overflows.
REQ-027 in_valid while in_ready=0 SHALL be ignored; the upstream stage SHALL hold the request until it is accepted.
REQ-028 Inputs SHALL be ignored outside the accept cycle; changes during SHIFT SHALL NOT affect the result.

Reset
REQ-029 rst=1 on a clock edge SHALL force IDLE, out_valid=0, result=0, zero=0, overflow=0 and shift counter=0.
REQ-030 rst SHALL take priority over any accept or handshake on the same edge.
REQ-031 rst during SHIFT or DONE SHALL abort the operation and discard the result; no out_valid pulse SHALL follow.
REQ-032 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-033 ADD a=0x7FFFFFFF, b=1 -> 1 cycle later: result=0x80000000, overflow=1, zero=0.
REQ-034 SUB a=5, b=5 -> result=0, zero=1, overflow=0; SLT a=0xFFFFFFFF, b=1 -> result=1.
REQ-035 SRA b=0x80000000, shift=4 -> out_valid exactly 5 edges after accept, result=0xF8000000; in_ready=0 throughout SHIFT.
REQ-036 SLL b=0x00001234, shift=16 (LUI path) -> result=0x12340000. SLL with shift=0 -> result=b, latency 1.
REQ-037 out_ready held 0 for 3 cycles in DONE -> result stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND a=0xF0F0F0F0, b=0xFF00FF00) -> accepted on the same edge, next result=0xF000F000.
REQ-038 rst asserted at the 2nd cycle of SRL shift=10 -> next cycle IDLE, out_valid=0. A following ADD 2+3 -> result=5 with normal latency.

Source files
------------

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec
// Description : 32-bit execute-stage ALU with valid/ready handshakes.
//               Logic and arithmetic ops finish in one cycle. Shifts run
//               serially, one bit per cycle, under a 5-bit down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_control_line,
  input  logic [4:0]  shift,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  // Operation codes as issued by the ALU control stage
  localparam logic [3:0] C_OP_AND = 4'b0000;
  localparam logic [3:0] C_OP_OR  = 4'b0001;
  localparam logic [3:0] C_OP_ADD = 4'b0010;
  localparam logic [3:0] C_OP_SLL = 4'b0011;
  localparam logic [3:0] C_OP_SRL = 4'b0100;
  localparam logic [3:0] C_OP_SRA = 4'b0101;
  localparam logic [3:0] C_OP_SUB = 4'b0110;
  localparam logic [3:0] C_OP_SLT = 4'b0111;
  localparam logic [3:0] C_OP_XOR = 4'b1000;
  localparam logic [3:0] C_OP_NOR = 4'b1100;

  // Shift flavour remembered for the serial shift phase
  localparam logic [1:0] C_SH_SLL = 2'd0;
  localparam logic [1:0] C_SH_SRL = 2'd1;
  localparam logic [1:0] C_SH_SRA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [31:0] result_q, result_d;
  logic        zero_q,   zero_d;
  logic        ovf_q,    ovf_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [1:0]  kind_q,   kind_d;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_alu_res;
  logic        w_alu_ovf;
  logic        w_is_shift;
  logic [1:0]  w_kind;
  logic [31:0] w_step;
  logic        w_accept;

  // Single-cycle ALU evaluated on the live request; shifts present b
  // unchanged so a zero-length shift completes straight away.
  always_comb begin
    w_sum      = a + b;
    w_diff     = a - b;
    w_alu_res  = 32'd0;
    w_alu_ovf  = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = C_SH_SLL;
    case (alu_control_line)
      C_OP_AND: w_alu_res = a & b;
      C_OP_OR:  w_alu_res = a | b;
      C_OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      C_OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);
      end
      // A true signed compare, so an overflowing a-b cannot flip the answer
      C_OP_SLT: w_alu_res = {31'd0, ($signed(a) < $signed(b))};
      C_OP_XOR: w_alu_res = a ^ b;
      C_OP_NOR: w_alu_res = ~(a | b);
      C_OP_SLL: begin
        w_alu_res  = b;
        w_is_shift = 1'b1;
        w_kind     = C_SH_SLL;
      end
      C_OP_SRL: begin
        w_alu_res  = b;
        w_is_shift = 1'b1;
        w_kind     = C_SH_SRL;
      end
      C_OP_SRA: begin
        w_alu_res  = b;
        w_is_shift = 1'b1;
        w_kind     = C_SH_SRA;
      end
      default: begin
        w_alu_res = 32'd0;
        w_alu_ovf = 1'b0;
      end
    endcase
  end

  // One-bit shift step of the working register; SRA keeps copying the
  // sign bit, which is b[31] because the MSB never changes during SRA.
  always_comb begin
    case (kind_q)
      C_SH_SRL: w_step = {1'b0, result_q[31:1]};
      C_SH_SRA: w_step = {result_q[31], result_q[31:1]};
      default:  w_step = {result_q[30:0], 1'b0};
    endcase
  end

  // Handshake: always ready when idle, ready in DONE only if the result
  // is being consumed on this same edge.
  always_comb begin
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    w_accept = in_valid && in_ready;
  end

  // Next-state and next-datapath computation
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          result_d = w_alu_res;
          zero_d   = (w_alu_res == 32'd0);
          ovf_d    = w_alu_ovf;
          kind_d   = w_kind;
          if (w_is_shift && (shift != 5'd0)) begin
            state_d = ST_SHIFT;
            cnt_d   = shift;
          end else begin
            state_d = ST_DONE;
            cnt_d   = 5'd0;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        result_d = w_step;
        zero_d   = (w_step == 32'd0);
        ovf_d    = 1'b0;
        cnt_d    = cnt_q - 5'd1;
        // Last step lands together with the move to DONE
        if (cnt_q <= 5'd1) begin
          state_d = ST_DONE;
          cnt_d   = 5'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State register with synchronous reset overriding any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= 5'd0;
      kind_q   <= C_SH_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire
